wb_commit_unit: RTL and testbench
=================================

// Module: wb_commit_unit
// PURPOSE
//  Parametrised writeback/commit stage. Selects the in-order pipeline result, extracts and extends load data
//  from funct3 + address offset, and merges results from a long-latency unit (mul/div) through a small FIFO.
//  All results share the single regfile write port, which is registered. Also keeps the retired-instruction count.
//  Sits after MEM; drives the regfile write port and the forwarding network.
// PARAMETERS
//  XLEN     32  datapath width (32 or 64; load extraction always covers byte/half/word)
//  LL_DEPTH 4   long-latency result FIFO entries (power of 2, >=2)
//  CNT_W    64  width of instret counter
// PORTS
//  clk          in  1        clock
//  rst          in  1        asynchronous reset, active-low
//  pipe_valid   in  1        in-order instruction retiring this cycle
//  pipe_sel     in  3        0 ALU, 1 BR_EN, 2 U_IMM, 3 LOAD, 4 PC_PLUS4; 5-7 illegal
//  pipe_funct3  in  3        load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  pipe_addr_lo in  2        load address bits [1:0]
//  pipe_rd      in  5        destination register
//  pipe_alu     in  XLEN     ALU result
//  pipe_br_en   in  1        compare result
//  pipe_uimm    in  XLEN     U-type immediate
//  pipe_mdr     in  XLEN     raw memory read word
//  pipe_pc      in  XLEN     instruction PC
//  ll_valid     in  1        long-latency result offered
//  ll_ready     out 1        FIFO can accept (count < LL_DEPTH)
//  ll_rd        in  5        long-latency destination
//  ll_data      in  XLEN     long-latency result
//  rf_we        out 1        regfile write enable (registered)
//  rf_rd        out 5        regfile write address (registered)
//  rf_wdata     out XLEN     regfile write data (registered)
//  load_err     out 1        one-cycle pulse: misaligned/illegal load, write suppressed
//  ll_count     out $clog2(LL_DEPTH)+1  FIFO occupancy
//  instret      out CNT_W    retired in-order instructions
// BEHAVIOUR
//  Reset (rst low, async): rf_we/rf_rd/rf_wdata/load_err/instret = 0, FIFO empty, ll_count = 0; ll_ready = 0 while rst low.
//  Latency: 1 cycle. Inputs sampled at rising edge appear on rf_* after that edge; rf_we is high for exactly one cycle per write.
//  Pipe value: ALU->pipe_alu; BR->zero-extended pipe_br_en; U_IMM->pipe_uimm; PC_PLUS4->pipe_pc+4 (mod 2^XLEN).
//  LOAD: lane = addr_lo. LB/LBU take byte[lane] and sign/zero extend. LH/LHU need addr_lo[0]=0 and take half[addr_lo[1]].
//   LW needs addr_lo=00; on XLEN=64 it sign-extends the low word.
//  Misaligned load or illegal funct3 (011,110,111): no write, load_err=1 next cycle; instret still increments.
//  Illegal pipe_sel with pipe_valid: no write, simulation $fatal.
//  Slot arbitration, per cycle, in priority order:
//   (1) pipe_valid && pipe_rd!=0 && no load error -> pipeline write, slot taken;
//   (2) else FIFO non-empty -> pop head and write it;
//   (3) else ll_valid && ll_ready -> bypass ll directly; no FIFO entry is created.
//  Push: ll_valid && ll_ready && not bypassed -> enqueue {ll_rd, ll_data}. A push and a pop in the same cycle leave count unchanged.
//  ll_ready = (ll_count < LL_DEPTH), from registered count only; it does not depend on ll_valid.
//   When full, ll_ready=0 even if a pop happens that cycle.
//  FIFO entries with rd=0 are popped and consume the slot with rf_we=0. x0 is never written by any source.
//  instret increments by 1 per pipe_valid, wraps at 2^CNT_W. Long-latency results are not counted.
//  Ordering: the upstream scoreboard guarantees no WAW between pipe and ll on the same rd; this block does not check it.
//  FIFO pointers wrap modulo LL_DEPTH; one extra count bit distinguishes full from empty.
// TESTING
//  1 LB/LBU on mdr=32'h80FF7F01, addr_lo 0..3 -> 00000001, 0000007F, FFFFFFFF/000000FF, FFFFFF80/00000080.
//  2 LH addr_lo=01 rd=5 -> rf_we=0, load_err=1 for one cycle, instret +1; LHU addr_lo=10 mdr=8001_xxxx -> 00008001.
//  3 Idle pipe, ll_valid rd=7 data=0x1234 -> bypass, next cycle rf_we=1, rf_rd=7, rf_wdata=0x1234, ll_count stays 0.
//  4 pipe_valid rd!=0 for 6 cycles, ll_valid held -> 4 accepted, ll_ready=0, count=4; pipe stops -> 4 in-order pops, then ll_ready=1.
//  5 pipe_valid rd=0 while FIFO holds rd=3 -> FIFO head written in that slot; PC_PLUS4 pc=FFFFFFFC -> 00000000.
//  6 rst low mid-drain (count=3) -> rf_we=0 and ll_count=0 at once; instret wraps from 2^CNT_W-1 to 0 (force CNT_W=4).

Source files
------------

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: selects the in-order result, extracts and extends
// load data, and shares the single registered regfile write port with a small
// long-latency result FIFO. Also counts retired in-order instructions.
module wb_commit_unit #(
  parameter int XLEN     = 32,
  parameter int LL_DEPTH = 4,
  parameter int CNT_W    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pipe_valid,
  input  logic [2:0]                  pipe_sel,
  input  logic [2:0]                  pipe_funct3,
  input  logic [1:0]                  pipe_addr_lo,
  input  logic [4:0]                  pipe_rd,
  input  logic [XLEN-1:0]             pipe_alu,
  input  logic                        pipe_br_en,
  input  logic [XLEN-1:0]             pipe_uimm,
  input  logic [XLEN-1:0]             pipe_mdr,
  input  logic [XLEN-1:0]             pipe_pc,
  input  logic                        ll_valid,
  output logic                        ll_ready,
  input  logic [4:0]                  ll_rd,
  input  logic [XLEN-1:0]             ll_data,
  output logic                        rf_we,
  output logic [4:0]                  rf_rd,
  output logic [XLEN-1:0]             rf_wdata,
  output logic                        load_err,
  output logic [$clog2(LL_DEPTH):0]   ll_count,
  output logic [CNT_W-1:0]            instret
);

  localparam int PW = $clog2(LL_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] SEL_ALU   = 3'd0;
  localparam logic [2:0] SEL_BR    = 3'd1;
  localparam logic [2:0] SEL_UIMM  = 3'd2;
  localparam logic [2:0] SEL_LOAD  = 3'd3;
  localparam logic [2:0] SEL_PC4   = 3'd4;

  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     word_v;
  logic [XLEN-1:0] load_v;
  logic            ld_bad;
  logic [XLEN-1:0] pipe_v;
  logic            sel_bad;
  logic            load_err_c;
  logic            pipe_take;
  logic            fifo_empty;
  logic            pop;
  logic            bypass;
  logic            push;
  logic            we_n;
  logic [4:0]      rd_n;
  logic [XLEN-1:0] wdata_n;

  logic [4:0]      fifo_rd   [LL_DEPTH];
  logic [XLEN-1:0] fifo_data [LL_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  // Load lane extraction and sign/zero extension; flags misaligned or illegal types.
  always_comb begin
    byte_v = 8'h00;
    ld_bad = 1'b0;
    load_v = '0;
    case (pipe_addr_lo)
      2'd0:    byte_v = pipe_mdr[7:0];
      2'd1:    byte_v = pipe_mdr[15:8];
      2'd2:    byte_v = pipe_mdr[23:16];
      default: byte_v = pipe_mdr[31:24];
    endcase
    half_v = pipe_addr_lo[1] ? pipe_mdr[31:16] : pipe_mdr[15:0];
    word_v = pipe_mdr[31:0];
    case (pipe_funct3)
      3'b000: load_v = XLEN'($signed(byte_v));
      3'b100: load_v = XLEN'(byte_v);
      3'b001: begin
        load_v = XLEN'($signed(half_v));
        ld_bad = pipe_addr_lo[0];
      end
      3'b101: begin
        load_v = XLEN'(half_v);
        ld_bad = pipe_addr_lo[0];
      end
      3'b010: begin
        load_v = XLEN'($signed(word_v));
        ld_bad = (pipe_addr_lo != 2'b00);
      end
      default: ld_bad = 1'b1;
    endcase
  end

  // In-order result select.
  always_comb begin
    pipe_v  = '0;
    sel_bad = 1'b0;
    case (pipe_sel)
      SEL_ALU:  pipe_v = pipe_alu;
      SEL_BR:   pipe_v = XLEN'(pipe_br_en);
      SEL_UIMM: pipe_v = pipe_uimm;
      SEL_LOAD: pipe_v = load_v;
      SEL_PC4:  pipe_v = pipe_pc + XLEN'(4);
      default:  sel_bad = 1'b1;
    endcase
  end

  // Write-slot arbitration: pipeline first, then FIFO head, then direct bypass.
  always_comb begin
    load_err_c = pipe_valid && (pipe_sel == SEL_LOAD) && ld_bad;
    pipe_take  = pipe_valid && (pipe_rd != 5'd0) && !load_err_c && !sel_bad;
    fifo_empty = (ll_count == '0);
    ll_ready   = rst && (ll_count < CW'(LL_DEPTH));
    pop        = !pipe_take && !fifo_empty;
    bypass     = !pipe_take && fifo_empty && ll_valid && ll_ready;
    push       = ll_valid && ll_ready && !bypass;
    we_n       = 1'b0;
    rd_n       = 5'd0;
    wdata_n    = '0;
    if (pipe_take) begin
      we_n    = 1'b1;
      rd_n    = pipe_rd;
      wdata_n = pipe_v;
    end else if (pop) begin
      we_n    = (fifo_rd[rd_ptr] != 5'd0);
      rd_n    = fifo_rd[rd_ptr];
      wdata_n = fifo_data[rd_ptr];
    end else if (bypass) begin
      we_n    = (ll_rd != 5'd0);
      rd_n    = ll_rd;
      wdata_n = ll_data;
    end
  end

  // Registered regfile write port, load error pulse and retired count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= 5'd0;
      rf_wdata <= '0;
      load_err <= 1'b0;
      instret  <= '0;
    end else begin
      rf_we    <= we_n;
      rf_rd    <= rd_n;
      rf_wdata <= wdata_n;
      load_err <= load_err_c;
      if (pipe_valid) instret <= instret + CNT_W'(1);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      ll_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   ll_count <= ll_count + CW'(1);
        2'b01:   ll_count <= ll_count - CW'(1);
        default: ll_count <= ll_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ll_rd;
      fifo_data[wr_ptr] <= ll_data;
    end
  end

  // Illegal result select on a retiring instruction stops simulation.
  always @(posedge clk) begin
    if (rst) assert (!(pipe_valid && sel_bad))
      else $fatal(1, "wb_commit_unit: illegal pipe_sel %0d", pipe_sel);
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: expected writes are queued as stimulus
// is driven and popped when the DUT asserts rf_we.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_valid = 1'b0;
  logic [2:0]  pipe_sel = 3'd0;
  logic [2:0]  pipe_funct3 = 3'd0;
  logic [1:0]  pipe_addr_lo = 2'd0;
  logic [4:0]  pipe_rd = 5'd0;
  logic [31:0] pipe_alu = '0;
  logic        pipe_br_en = 1'b0;
  logic [31:0] pipe_uimm = '0;
  logic [31:0] pipe_mdr = '0;
  logic [31:0] pipe_pc = '0;
  logic        ll_valid = 1'b0;
  logic [4:0]  ll_rd = 5'd0;
  logic [31:0] ll_data = '0;

  logic        ll_ready, rf_we, load_err;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [2:0]  ll_count;
  logic [63:0] instret;

  logic        ll_ready4, rf_we4, load_err4;
  logic [4:0]  rf_rd4;
  logic [31:0] rf_wdata4;
  logic [2:0]  ll_count4;
  logic [3:0]  instret4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] sb_q[$];
  logic [63:0] exp_ir = 0;

  always #5 clk = ~clk;

  wb_commit_unit #(.XLEN(32), .LL_DEPTH(4), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .pipe_valid(pipe_valid), .pipe_sel(pipe_sel),
    .pipe_funct3(pipe_funct3), .pipe_addr_lo(pipe_addr_lo), .pipe_rd(pipe_rd),
    .pipe_alu(pipe_alu), .pipe_br_en(pipe_br_en), .pipe_uimm(pipe_uimm),
    .pipe_mdr(pipe_mdr), .pipe_pc(pipe_pc), .ll_valid(ll_valid), .ll_ready(ll_ready),
    .ll_rd(ll_rd), .ll_data(ll_data), .rf_we(rf_we), .rf_rd(rf_rd),
    .rf_wdata(rf_wdata), .load_err(load_err), .ll_count(ll_count), .instret(instret)
  );

  wb_commit_unit #(.XLEN(32), .LL_DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .pipe_valid(pipe_valid), .pipe_sel(pipe_sel),
    .pipe_funct3(pipe_funct3), .pipe_addr_lo(pipe_addr_lo), .pipe_rd(pipe_rd),
    .pipe_alu(pipe_alu), .pipe_br_en(pipe_br_en), .pipe_uimm(pipe_uimm),
    .pipe_mdr(pipe_mdr), .pipe_pc(pipe_pc), .ll_valid(ll_valid), .ll_ready(ll_ready4),
    .ll_rd(ll_rd), .ll_data(ll_data), .rf_we(rf_we4), .rf_rd(rf_rd4),
    .rf_wdata(rf_wdata4), .load_err(load_err4), .ll_count(ll_count4), .instret(instret4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write the DUT makes must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && rf_we) begin
      if (sb_q.size() == 0) check("sb_unexpected_write", {59'd0, rf_rd}, 64'hFFFF);
      else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        check("sb_rd", 64'(rf_rd), 64'(e[36:32]));
        check("sb_data", 64'(rf_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_valid = 1'b0;
    ll_valid   = 1'b0;
  endtask

  // Drive one in-order non-load op; operand fields are set by the caller.
  task automatic pipe_op(input logic [2:0] sel, input logic [4:0] rd, input logic [31:0] exp);
    pipe_valid = 1'b1;
    pipe_sel   = sel;
    pipe_rd    = rd;
    if (rd != 5'd0) sb_q.push_back({rd, exp});
    exp_ir++;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [1:0] alo, input logic [4:0] rd,
                    input logic [31:0] mdr, input logic [31:0] exp, input logic err);
    pipe_valid   = 1'b1;
    pipe_sel     = 3'd3;
    pipe_funct3  = f3;
    pipe_addr_lo = alo;
    pipe_rd      = rd;
    pipe_mdr     = mdr;
    ll_valid     = 1'b0;
    if (!err && rd != 5'd0) sb_q.push_back({rd, exp});
    exp_ir++;
    tick();
    check("load_err", 64'(load_err), 64'(err));
  endtask

  initial begin
    #1;
    check("rst_rf_we", 64'(rf_we), 0);
    check("rst_ll_count", 64'(ll_count), 0);
    check("rst_ll_ready", 64'(ll_ready), 0);
    check("rst_instret", instret, 0);
    check("rst_load_err", 64'(load_err), 0);
    #12 rst = 1'b1;
    tick();
    check("ll_ready_after_rst", 64'(ll_ready), 1);

    // byte / half / word loads
    ld(3'b000, 2'd0, 5'd1, 32'h80FF7F01, 32'h00000001, 1'b0);
    ld(3'b000, 2'd1, 5'd1, 32'h80FF7F01, 32'h0000007F, 1'b0);
    ld(3'b000, 2'd2, 5'd1, 32'h80FF7F01, 32'hFFFFFFFF, 1'b0);
    ld(3'b000, 2'd3, 5'd1, 32'h80FF7F01, 32'hFFFFFF80, 1'b0);
    ld(3'b100, 2'd0, 5'd2, 32'h80FF7F01, 32'h00000001, 1'b0);
    ld(3'b100, 2'd1, 5'd2, 32'h80FF7F01, 32'h0000007F, 1'b0);
    ld(3'b100, 2'd2, 5'd2, 32'h80FF7F01, 32'h000000FF, 1'b0);
    ld(3'b100, 2'd3, 5'd2, 32'h80FF7F01, 32'h00000080, 1'b0);
    ld(3'b001, 2'd2, 5'd3, 32'h80FF7F01, 32'hFFFF80FF, 1'b0);
    ld(3'b001, 2'd0, 5'd3, 32'h80FF7F01, 32'h00007F01, 1'b0);
    ld(3'b010, 2'd0, 5'd4, 32'h80FF7F01, 32'h80FF7F01, 1'b0);
    ld(3'b001, 2'd1, 5'd5, 32'h80FF7F01, 32'h0, 1'b1);
    ld(3'b101, 2'd2, 5'd5, 32'h80011234, 32'h00008001, 1'b0);
    ld(3'b011, 2'd0, 5'd6, 32'h12345678, 32'h0, 1'b1);
    ld(3'b010, 2'd2, 5'd6, 32'h12345678, 32'h0, 1'b1);
    idle();
    tick();
    check("load_err_pulse_end", 64'(load_err), 0);
    check("instret_loads", instret, exp_ir);

    // ALU / BR / U_IMM
    pipe_alu = 32'hDEADBEEF; pipe_op(3'd0, 5'd1, 32'hDEADBEEF); tick();
    pipe_br_en = 1'b1;       pipe_op(3'd1, 5'd2, 32'h1);        tick();
    pipe_uimm = 32'h12345000; pipe_op(3'd2, 5'd3, 32'h12345000); tick();
    idle();

    // direct bypass of a long-latency result
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h1234;
    sb_q.push_back({5'd7, 32'h1234});
    tick();
    idle();
    check("bypass_count", 64'(ll_count), 0);
    tick();

    // FIFO fill while the pipeline holds the slot, then in-order drain
    for (int i = 0; i < 6; i++) begin
      pipe_alu = 32'hA000 + i;
      pipe_op(3'd0, 5'(1 + i), 32'hA000 + i);
      ll_valid = 1'b1;
      ll_rd    = 5'(8 + i);
      ll_data  = 32'hB000 + i;
      tick();
      check("fill_count", 64'(ll_count), (i < 3) ? i + 1 : 4);
      check("fill_ready", 64'(ll_ready), (i < 3) ? 1 : 0);
    end
    idle();
    for (int i = 0; i < 4; i++) sb_q.push_back({5'(8 + i), 32'hB000 + i});
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_count", 64'(ll_count), 3 - i);
    end
    check("drain_ready", 64'(ll_ready), 1);

    // pipe rd=0 yields its slot to the FIFO head
    pipe_alu = 32'h44; pipe_op(3'd0, 5'd4, 32'h44);
    ll_valid = 1'b1; ll_rd = 5'd3; ll_data = 32'h333;
    tick();
    check("head_count", 64'(ll_count), 1);
    ll_valid = 1'b0;
    pipe_alu = 32'h55; pipe_op(3'd0, 5'd0, 32'h0);
    sb_q.push_back({5'd3, 32'h333});
    tick();
    check("head_pop_count", 64'(ll_count), 0);
    // rd=0 FIFO entry consumes a slot without writing
    pipe_alu = 32'h99; pipe_op(3'd0, 5'd9, 32'h99);
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h5555;
    tick();
    idle();
    tick();
    check("x0_pop_count", 64'(ll_count), 0);
    check("x0_pop_we", 64'(rf_we), 0);
    pipe_pc = 32'hFFFFFFFC; pipe_op(3'd4, 5'd6, 32'h00000000); tick();
    idle();
    tick();
    check("instret_mid", instret, exp_ir);
    check("instret4_mid", 64'(instret4), 64'(exp_ir[3:0]));
    check("sb_empty_mid", 64'(sb_q.size()), 0);

    // reset mid-drain with three entries left
    for (int i = 0; i < 4; i++) begin
      pipe_alu = 32'hC000 + i;
      pipe_op(3'd0, 5'(20 + i), 32'hC000 + i);
      ll_valid = 1'b1; ll_rd = 5'(24 + i); ll_data = 32'hD000 + i;
      tick();
    end
    idle();
    sb_q.push_back({5'd24, 32'hD000});
    tick();
    check("pre_rst_count", 64'(ll_count), 3);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_we", 64'(rf_we), 0);
    check("rst_mid_count", 64'(ll_count), 0);
    check("rst_mid_ready", 64'(ll_ready), 0);
    check("rst_mid_instret", instret, 0);
    sb_q.delete();
    #2 rst = 1'b1;
    exp_ir = 0;
    tick();

    // instret wrap on the narrow counter
    for (int i = 0; i < 15; i++) begin
      pipe_alu = 32'h0; pipe_op(3'd0, 5'd0, 32'h0);
      tick();
    end
    check("instret4_max", 64'(instret4), 15);
    tick();
    idle();
    check("instret4_wrap", 64'(instret4), 0);
    check("instret_16", instret, 16);
    tick();
    tick();
    check("sb_empty_end", 64'(sb_q.size()), 0);
    check("end_count", 64'(ll_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
